// File: rtl/lfsr_sng.sv
// LFSR-driven stochastic number generator: a Fibonacci LFSR compared against a
// latched probability word emits a framed LEN-bit stream and counts its ones.
module lfsr_sng #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8),
    parameter int               LEN   = 255,
    parameter int               CNTW  = $clog2(LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] seed,
    input  logic             load,
    input  logic [WIDTH-1:0] prob,
    input  logic             start,
    input  logic             en,
    output logic             q,
    output logic             valid,
    output logic             done,
    output logic             busy,
    output logic [CNTW-1:0]  ones_cnt,
    output logic [WIDTH-1:0] lfsr_state
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNTW-1:0]  LAST_IDX = CNTW'(LEN - 1);
    localparam logic [WIDTH-1:0] ONE_WORD = WIDTH'(1);

    state_t           state_reg;
    state_t           state_next;

    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] prob_reg;
    logic [CNTW-1:0]  cnt_reg;
    logic [CNTW-1:0]  ones_reg;
    logic             q_reg;
    logic             valid_reg;
    logic             done_reg;

    logic             step_en;
    logic             load_ok;
    logic             start_ok;
    logic             last_bit;
    logic             hit;

    logic [WIDTH-1:0] tap_terms;
    logic             fb;
    logic [WIDTH-1:0] r_step;

    // Feedback is the parity of the tapped register bits.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tap
        assign tap_terms[gi] = r_reg[gi] & TAPS[gi];
    end

    assign fb     = ^tap_terms;
    assign r_step = {r_reg[WIDTH-2:0], fb};
    assign hit    = (r_reg <= prob_reg);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (en && (cnt_reg == LAST_IDX)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_reg == RUN);
        step_en  = (state_reg == RUN) && en;
        load_ok  = (state_reg == IDLE) && load;
        start_ok = (state_reg == IDLE) && start;
        last_bit = step_en && (cnt_reg == LAST_IDX);
    end

    // Load and start share an IDLE cycle cleanly: load owns r, start owns the
    // run bookkeeping, so the first RUN step already sees the new seed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reg     <= ONE_WORD;
            prob_reg  <= '0;
            cnt_reg   <= '0;
            ones_reg  <= '0;
            q_reg     <= 1'b0;
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            valid_reg <= step_en;
            done_reg  <= last_bit;

            if (load_ok) begin
                r_reg <= (seed == '0) ? ONE_WORD : seed;
            end else if (step_en) begin
                r_reg <= r_step;
            end

            if (start_ok) begin
                prob_reg <= prob;
                cnt_reg  <= '0;
                ones_reg <= '0;
            end else if (step_en) begin
                q_reg    <= hit;
                ones_reg <= ones_reg + CNTW'(hit);
                cnt_reg  <= cnt_reg + CNTW'(1);
            end
        end
    end

    assign q          = q_reg;
    assign valid      = valid_reg;
    assign done       = done_reg;
    assign ones_cnt   = ones_reg;
    assign lfsr_state = r_reg;

endmodule
